// File: rtl/d_cache_if.sv
// CPU-side and memory-side bus of the data cache.
// The slave modport is the cache itself; master is the CPU/memory environment.
interface d_cache_if #(
  parameter int FETCH_SIZE = 64
);
  logic                  d_readC;
  logic                  d_writeC;
  logic [15:0]           d_addressC;
  logic [15:0]           d_wdataC;
  logic [15:0]           d_rdataC;
  logic                  d_readyC;
  logic                  invalidate;
  logic                  d_readM;
  logic                  d_writeM;
  logic [15:0]           d_addressM;
  logic [15:0]           d_wdataM;
  logic [FETCH_SIZE-1:0] d_rdataM;
  logic                  d_cache_hit;
  logic [15:0]           hit_count;
  logic [15:0]           miss_count;

  modport slave (
    input  d_readC, d_writeC, d_addressC, d_wdataC, invalidate, d_rdataM,
    output d_rdataC, d_readyC, d_readM, d_writeM, d_addressM, d_wdataM,
           d_cache_hit, hit_count, miss_count
  );

  modport master (
    output d_readC, d_writeC, d_addressC, d_wdataC, invalidate, d_rdataM,
    input  d_rdataC, d_readyC, d_readM, d_writeM, d_addressM, d_wdataM,
           d_cache_hit, hit_count, miss_count
  );
endinterface

// File: rtl/d_cache.sv
// Direct-mapped 4x4-word write-through, no-write-allocate data cache.
// reset_n is active-high despite its name (the legacy port name is kept).
module d_cache #(
  parameter int MEM_LATENCY = 4,
  parameter int FETCH_SIZE  = 64
) (
  input logic       clk,
  input logic       reset_n,
  d_cache_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, COMPARE, FILL, WRITE} state_t;

  localparam int CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(MEM_LATENCY - 1);

  state_t          state, nextState;
  logic            isWrite;
  logic            fillDone;
  logic [15:0]     addrLat;
  logic [15:0]     wdataLat;
  logic [CntW-1:0] latCnt;
  logic [3:0]      valid;
  logic [15:0]     hitCount;
  logic [15:0]     missCount;
  logic [11:0]     tagArr  [4];
  logic [15:0]     dataArr [4][4];

  logic [11:0] tag;
  logic [1:0]  index;
  logic [1:0]  offset;
  logic        hit;
  logic        lastCycle;

  assign tag       = addrLat[15:4];
  assign index     = addrLat[3:2];
  assign offset    = addrLat[1:0];
  assign hit       = valid[index] && (tagArr[index] == tag);
  assign lastCycle = (latCnt == LastCnt);

  assign bus.hit_count  = hitCount;
  assign bus.miss_count = missCount;

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    nextState       = state;
    bus.d_rdataC    = '0;
    bus.d_readyC    = 1'b0;
    bus.d_cache_hit = 1'b0;
    bus.d_readM     = 1'b0;
    bus.d_writeM    = 1'b0;
    bus.d_addressM  = '0;
    bus.d_wdataM    = '0;
    unique case (state)
      IDLE: begin
        if (bus.d_writeC || bus.d_readC) nextState = COMPARE;
      end
      COMPARE: begin
        if (isWrite) begin
          nextState = WRITE;
        end else if (hit) begin
          bus.d_readyC    = 1'b1;
          bus.d_rdataC    = dataArr[index][offset];
          bus.d_cache_hit = !fillDone;
          nextState       = IDLE;
        end else begin
          nextState = FILL;
        end
      end
      FILL: begin
        bus.d_readM    = 1'b1;
        bus.d_addressM = {tag, index, 2'b00};
        if (lastCycle) nextState = COMPARE;
      end
      WRITE: begin
        bus.d_writeM   = 1'b1;
        bus.d_addressM = addrLat;
        bus.d_wdataM   = wdataLat;
        if (lastCycle) begin
          bus.d_readyC = 1'b1;
          nextState    = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state     <= IDLE;
      isWrite   <= 1'b0;
      fillDone  <= 1'b0;
      addrLat   <= '0;
      wdataLat  <= '0;
      latCnt    <= '0;
      valid     <= '0;
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      state <= nextState;
      unique case (state)
        IDLE: begin
          if (bus.invalidate) valid <= '0;
          if (bus.d_writeC) begin
            isWrite  <= 1'b1;
            addrLat  <= bus.d_addressC;
            wdataLat <= bus.d_wdataC;
            fillDone <= 1'b0;
          end else if (bus.d_readC) begin
            isWrite  <= 1'b0;
            addrLat  <= bus.d_addressC;
            fillDone <= 1'b0;
          end
        end
        COMPARE: begin
          if (!isWrite) begin
            // The re-lookup after a fill completes the miss; it is not a new hit.
            if (hit && !fillDone) hitCount <= hitCount + 16'd1;
            if (!hit)             missCount <= missCount + 16'd1;
          end
        end
        FILL: begin
          latCnt <= lastCycle ? '0 : latCnt + 1'b1;
          if (lastCycle) begin
            valid[index] <= 1'b1;
            fillDone     <= 1'b1;
          end
        end
        WRITE: begin
          latCnt <= lastCycle ? '0 : latCnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: tag/data storage has no reset; the valid bits alone decide whether it is used.
  always_ff @(posedge clk) begin
    if (state == COMPARE && isWrite && hit) begin
      dataArr[index][offset] <= wdataLat;
    end
    if (state == FILL && lastCycle) begin
      tagArr[index] <= tag;
      for (int k = 0; k < 4; k++) begin
        dataArr[index][k] <= bus.d_rdataM[16*k +: 16];
      end
    end
  end
endmodule

// File: tb/tb_d_cache.sv
// Directed bench for d_cache: word-addressed memory model plus hand-computed
// latencies, data and counter values for each access.
module tb_d_cache;
  logic clk = 1'b0;
  logic reset_n;

  d_cache_if #(.FETCH_SIZE(64)) bus ();

  d_cache #(.MEM_LATENCY(4), .FETCH_SIZE(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory: default word value is addr ^ 0x5A5A; the line is served combinationally.
  logic [15:0] mem [0:65535];
  logic [15:0] lineBase;
  assign lineBase     = {bus.d_addressM[15:2], 2'b00};
  assign bus.d_rdataM = {mem[lineBase + 16'd3], mem[lineBase + 16'd2],
                         mem[lineBase + 16'd1], mem[lineBase]};

  int          rdCycles;
  int          wrCycles;
  logic [15:0] rdAddr;
  logic [15:0] wrAddr;
  logic [15:0] wrData;
  logic        bothSeen = 1'b0;

  always @(negedge clk) begin
    if (bus.d_readM) begin
      rdCycles++;
      rdAddr = bus.d_addressM;
    end
    if (bus.d_writeM) begin
      wrCycles++;
      wrAddr = bus.d_addressM;
      wrData = bus.d_wdataM;
      mem[bus.d_addressM] = bus.d_wdataM;
    end
    if (bus.d_readM && bus.d_writeM) bothSeen = 1'b1;
  end

  // One CPU access: latency counts cycles from the accepting edge to the d_readyC cycle.
  task automatic access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        output logic [15:0] rdata, output logic hitFlag, output int lat,
                        output logic zeroBad);
    @(negedge clk);
    rdCycles = 0;
    wrCycles = 0;
    bus.d_readC    = !wr;
    bus.d_writeC   = wr;
    bus.d_addressC = addr;
    bus.d_wdataC   = wdata;
    @(posedge clk);
    lat = 0; rdata = '0; hitFlag = 1'b0; zeroBad = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.d_readyC) begin
        lat     = i;
        rdata   = bus.d_rdataC;
        hitFlag = bus.d_cache_hit;
        break;
      end else if (bus.d_rdataC != 16'h0) begin
        zeroBad = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.d_readC  = 1'b0;
    bus.d_writeC = 1'b0;
  endtask

  task automatic readChk(input string name, input logic [15:0] addr, input logic [15:0] expData,
                         input int expLat);
    logic [15:0] rdata;
    logic        hitFlag;
    int          lat;
    logic        zeroBad;
    access(1'b0, addr, 16'h0, rdata, hitFlag, lat, zeroBad);
    check({name, "_latency"}, lat, expLat);
    check({name, "_rdata"}, rdata, expData);
    check({name, "_rdata_zero_when_not_ready"}, zeroBad, 1'b0);
    if (expLat == 1) check({name, "_hit_flag"}, hitFlag, 1'b1);
    else check({name, "_fill_cycles"}, rdCycles, 4);
  endtask

  task automatic writeChk(input string name, input logic [15:0] addr, input logic [15:0] data);
    logic [15:0] rdata;
    logic        hitFlag;
    int          lat;
    logic        zeroBad;
    access(1'b1, addr, data, rdata, hitFlag, lat, zeroBad);
    check({name, "_latency"}, lat, 5);
    check({name, "_rdata_zero"}, rdata, 16'h0);
    check({name, "_mem_write_cycles"}, wrCycles, 4);
    check({name, "_mem_write_addr"}, wrAddr, addr);
    check({name, "_mem_write_data"}, wrData, data);
    check({name, "_no_mem_read"}, rdCycles, 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    mem[16'h0014] = 16'h1111;
    mem[16'h0015] = 16'h2222;
    mem[16'h0016] = 16'h3333;
    mem[16'h0017] = 16'h4444;
    bus.d_readC = 1'b0; bus.d_writeC = 1'b0; bus.invalidate = 1'b0;
    bus.d_addressC = '0; bus.d_wdataC = '0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_readyC", bus.d_readyC, 1'b0);
    check("reset_readM", bus.d_readM, 1'b0);
    check("reset_writeM", bus.d_writeM, 1'b0);
    check("reset_hit_count", bus.hit_count, 16'h0);
    check("reset_miss_count", bus.miss_count, 16'h0);
    check("reset_rdataC", bus.d_rdataC, 16'h0);
    reset_n = 1'b0;

    readChk("rd15_miss", 16'h0015, 16'h2222, 6);
    check("rd15_fill_addr", rdAddr, 16'h0014);
    check("rd15_miss_count", bus.miss_count, 16'd1);
    check("rd15_hit_count", bus.hit_count, 16'd0);

    readChk("rd17_hit", 16'h0017, 16'h4444, 1);
    check("rd17_hit_count", bus.hit_count, 16'd1);

    writeChk("wr16_hit", 16'h0016, 16'hBEEF);
    readChk("rd16_after_write", 16'h0016, 16'hBEEF, 1);
    check("rd16_hit_count", bus.hit_count, 16'd2);

    writeChk("wr100_miss", 16'h0100, 16'h1234);
    readChk("rd100_miss", 16'h0100, 16'h1234, 6);
    check("rd100_miss_count", bus.miss_count, 16'd2);

    readChk("rd24_conflict", 16'h0024, 16'h5A7E, 6);
    check("rd24_fill_addr", rdAddr, 16'h0024);
    check("rd24_hit_count_unchanged", bus.hit_count, 16'd2);
    readChk("rd14_evicted", 16'h0014, 16'h1111, 6);
    check("rd14_miss_count", bus.miss_count, 16'd4);

    // Reset on the second FILL cycle.
    @(negedge clk);
    bus.d_readC = 1'b1;
    bus.d_addressC = 16'h0034;
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("midfill_readM_active", bus.d_readM, 1'b1);
    reset_n = 1'b1;
    #1;
    check("midfill_reset_readM", bus.d_readM, 1'b0);
    check("midfill_reset_addressM", bus.d_addressM, 16'h0);
    check("midfill_reset_readyC", bus.d_readyC, 1'b0);
    check("midfill_reset_miss_count", bus.miss_count, 16'h0);
    bus.d_readC = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;

    readChk("rd34_after_reset", 16'h0034, 16'h5A6E, 6);
    check("rd34_miss_count", bus.miss_count, 16'd1);
    readChk("rd34_hit", 16'h0034, 16'h5A6E, 1);

    @(negedge clk);
    bus.invalidate = 1'b1;
    @(negedge clk);
    bus.invalidate = 1'b0;
    readChk("rd34_after_invalidate", 16'h0034, 16'h5A6E, 6);
    check("rd34_inv_miss_count", bus.miss_count, 16'd2);
    check("rd34_inv_hit_count", bus.hit_count, 16'd1);

    check("readM_writeM_exclusive", bothSeen, 1'b0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end
endmodule

// File: doc/d_cache.md
D_CACHE -- requirements
Module: d_cache

Interface
REQ-001 The block SHALL provide parameter MEM_LATENCY, default 4, meaning memory access cycles per read fill or write-through.
REQ-002 The block SHALL provide parameter FETCH_SIZE, default 64, meaning the width of a memory line read in bits.
REQ-003 The block SHALL have these ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-high reset (1 = reset), despite the name.
- d_readC  in  1  CPU read request; held until d_readyC.
- d_writeC  in  1  CPU write request; held until d_readyC.
- d_addressC  in  16  CPU word address.
- d_wdataC  in  16  CPU write data.
- d_rdataC  out  16  read data; valid while d_readyC=1 on a read.
- d_readyC  out  1  one-cycle completion pulse.
- invalidate  in  1  clear all valid bits.
- d_readM  out  1  memory line read.
- d_writeM  out  1  memory word write.
- d_addressM  out  16  memory address.
- d_wdataM  out  16  memory write data.
- d_rdataM  in  FETCH_SIZE  memory line data; word k at bits [16k+15:16k].
- d_cache_hit  out  1  pulses with d_readyC on a read hit.
- hit_count  out  16  read hits since reset.
- miss_count  out  16  read misses since reset.

Function
REQ-004 Geometry SHALL be direct-mapped, 4 lines x 4 words: offset = addr[1:0], index = addr[3:2], tag = addr[15:4]; one valid bit per line.
REQ-005 Policy SHALL be write-through, no-write-allocate.
REQ-006 The FSM SHALL have states IDLE, COMPARE, FILL, WRITE.
REQ-007 IDLE: if d_writeC=1, latch address and data and go to COMPARE as a write; else if d_readC=1, latch the address and go to COMPARE as a read. If both are set, the request is treated as a write.
REQ-008 COMPARE, read hit (valid and tag match): drive d_rdataC with the addressed word, pulse d_readyC and d_cache_hit, increment hit_count, go to IDLE. Hit latency is 1 cycle after acceptance.
REQ-009 COMPARE, read miss: increment miss_count and go to FILL.
REQ-010 COMPARE, write: on a hit, update the cached word in the same cycle; on a miss, leave cache contents unchanged; go to WRITE.
REQ-011 FILL: hold d_readM=1 and d_addressM={tag,index,2'b00} for exactly MEM_LATENCY cycles. On the last cycle, write d_rdataM into the line, set tag and valid, and go to COMPARE. The re-lookup is then a hit but SHALL NOT increment hit_count.
REQ-012 Read-miss latency SHALL be MEM_LATENCY+2 cycles from acceptance to d_readyC.
REQ-013 WRITE: hold d_writeM=1 with the latched d_addressM and d_wdataM for MEM_LATENCY cycles; pulse d_readyC on the last cycle, then go to IDLE.
REQ-014 d_readM and d_writeM SHALL never both be 1, and both SHALL be 0 outside FILL and WRITE.
REQ-015 The requester drops its request in the cycle after d_readyC. A request still asserted in IDLE is accepted as a new access.
REQ-016 invalidate SHALL take effect only in IDLE, clearing all valid bits in one cycle. When asserted outside IDLE, it SHALL be ignored.
REQ-017 hit_count and miss_count SHALL wrap modulo 2^16.
REQ-018 d_rdataC SHALL be 0 whenever d_readyC=0 or the access is a write.

Reset
REQ-019 When reset_n=1, the block SHALL immediately enter IDLE, clear all valid bits, zero both counters and the latency counter, and drive every output to 0, without waiting for a clock edge.
REQ-020 Reset asserted mid-FILL or mid-WRITE SHALL abort the access with no line update and no d_readyC.
REQ-021 Tag and data arrays need not be reset; valid bits gate their use.

Verification
REQ-022 Read 0x0015 after reset, memory line 0x0014 = {0x4444,0x3333,0x2222,0x1111} -> d_readM for 4 cycles at 0x0014, d_readyC 6 cycles after accept, d_rdataC=0x2222, miss_count=1.
REQ-023 Immediate second read of 0x0017 -> d_readyC 1 cycle after accept, d_rdataC=0x4444, d_cache_hit=1, hit_count=1.
REQ-024 Write 0xBEEF to 0x0016 (hit) -> d_writeM 4 cycles at 0x0016 with data 0xBEEF; a following read of 0x0016 hits and returns 0xBEEF.
REQ-025 Write to 0x0100 (miss) -> memory written, no d_readM; a following read of 0x0100 misses.
REQ-026 Read 0x0024 (same index as 0x0014, different tag) -> miss, refill, line replaced; a read of 0x0014 then misses.
REQ-027 Assert reset on the 2nd FILL cycle -> outputs 0 immediately; after release, a read of the same address misses again; assert invalidate in IDLE -> the next read of a cached address misses.
